// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI initiator that clocks one WIDTH-bit frame out of a
// shift-out responder once its done flag rises. The assembled word is handed
// to the local consumer over a valid/ready handshake.
//
// Parameters
//   WIDTH    bits per frame (>= 2)
//   CLK_DIV  clk cycles per sck half-period (>= 1)
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   done       responder frame-ready flag (asynchronous, synchronized here)
//   sdi        serial data from the responder, sampled on rising sck
//   sck        serial clock, idles low (registered)
//   out_data   received frame, first received bit in the MSB (registered)
//   out_valid  out_data holds a complete, unconsumed frame (registered)
//   out_ready  consumer accepts the frame when out_valid is also high
module spi_frame_rx #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done,
  input  logic             sdi,
  output logic             sck,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH);

  typedef enum logic [2:0] {
    S_REARM,
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_PRESENT
  } state_t;

  state_t           state_q, state_d;
  logic             done_m, done_s;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sck_d;
  logic [WIDTH-1:0] data_d;
  logic             valid_d;
  logic             div_tc;

  assign div_tc = (div_q == DIV_LAST);

  // State and datapath registers. The synchronizer resets to 1 so that a
  // done flag already high at reset release keeps REARM waiting for a real
  // low instead of seeing the reset value and capturing a stale frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_m    <= 1'b1;
      done_s    <= 1'b1;
      state_q   <= S_REARM;
      div_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      sck       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      done_m    <= done;
      done_s    <= done_m;
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      sck       <= sck_d;
      out_data  <= data_d;
      out_valid <= valid_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sck_d   = sck;
    data_d  = out_data;
    valid_d = out_valid;

    case (state_q)
      S_REARM: begin
        sck_d = 1'b0;
        if (!done_s) state_d = S_IDLE;
      end

      S_IDLE: begin
        sck_d = 1'b0;
        if (done_s) begin
          state_d = S_LEAD;
          div_d   = '0;
          bit_d   = '0;
        end
      end

      // The edge leaving LEAD is the first rising sck, so MSB settle time is
      // exactly one half-period.
      S_LEAD: begin
        if (div_tc) begin
          div_d   = '0;
          sck_d   = 1'b1;
          shreg_d = {shreg_q[WIDTH-2:0], sdi};
          bit_d   = bit_q + CNT_W'(1);
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      // Rising toggles sample sdi; the falling toggle after the last sample
      // ends the frame and publishes the word on the same edge.
      S_SHIFT: begin
        if (div_tc) begin
          div_d = '0;
          sck_d = ~sck;
          if (!sck) begin
            shreg_d = {shreg_q[WIDTH-2:0], sdi};
            if (bit_q != BIT_LAST) bit_d = bit_q + CNT_W'(1);
          end else if (bit_q == BIT_LAST) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_PRESENT;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_PRESENT: begin
        sck_d = 1'b0;
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          state_d = S_REARM;
        end
      end

      default: begin
        sck_d   = 1'b0;
        state_d = S_REARM;
      end
    endcase
  end

endmodule
